// File: rtl/time_countdown.sv
// Loadable MM:SS countdown timer with run/pause control, one-cycle done pulse and sticky expiry flag.
// Optional build macro TIME_COUNTDOWN_AUTORELOAD_EN: on expiry in RUN, reload the saved preset and keep running.
module time_countdown #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       stop,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'(MAX_MIN);

    logic [1:0] r_state;
    logic [5:0] r_sec;
    logic [5:0] r_min;
    logic       r_running;
    logic       r_done;
    logic       r_expired;

    logic [1:0] w_nxt_state;
    logic [5:0] w_nxt_sec;
    logic [5:0] w_nxt_min;
    logic       w_nxt_done;
    logic       w_nxt_expired;

    logic [5:0] w_clamp_sec;
    logic [5:0] w_clamp_min;
    logic [5:0] w_dec_sec;
    logic [5:0] w_dec_min;
    logic       w_dec_zero;
    logic       w_is_zero;

`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
    logic [5:0] r_pre_sec;
    logic [5:0] r_pre_min;
    logic       w_pre_nonzero;

    assign w_pre_nonzero = (r_pre_sec != 6'd0) || (r_pre_min != 6'd0);
`endif

    assign w_clamp_sec = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
    assign w_clamp_min = (load_min > MIN_MAX) ? MIN_MAX : load_min;

    // Borrow from minutes when seconds are exhausted; saturate at 00:00.
    assign w_dec_sec  = (r_sec != 6'd0) ? (r_sec - 6'd1)
                      : ((r_min != 6'd0) ? SEC_MAX : 6'd0);
    assign w_dec_min  = ((r_sec == 6'd0) && (r_min != 6'd0)) ? (r_min - 6'd1) : r_min;
    assign w_dec_zero = (w_dec_sec == 6'd0) && (w_dec_min == 6'd0);
    assign w_is_zero  = (r_sec == 6'd0) && (r_min == 6'd0);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_sec     = r_sec;
        w_nxt_min     = r_min;
        w_nxt_done    = 1'b0;
        w_nxt_expired = r_expired;

        if (load) begin
            w_nxt_state   = ST_IDLE;
            w_nxt_sec     = w_clamp_sec;
            w_nxt_min     = w_clamp_min;
            w_nxt_expired = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_is_zero) begin
                            w_nxt_state   = ST_DONE;
                            w_nxt_done    = 1'b1;
                            w_nxt_expired = 1'b1;
                        end else begin
                            w_nxt_state = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_nxt_state = ST_PAUSE;
                    end else if (tick) begin
                        w_nxt_sec = w_dec_sec;
                        w_nxt_min = w_dec_min;
                        if (w_dec_zero) begin
                            w_nxt_done = 1'b1;
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
                            if (w_pre_nonzero) begin
                                w_nxt_sec = r_pre_sec;
                                w_nxt_min = r_pre_min;
                            end else begin
                                w_nxt_state   = ST_DONE;
                                w_nxt_expired = 1'b1;
                            end
`else
                            w_nxt_state   = ST_DONE;
                            w_nxt_expired = 1'b1;
`endif
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        w_nxt_state = ST_RUN;
                    end
                end
                default: begin
                    w_nxt_sec = 6'd0;
                    w_nxt_min = 6'd0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sec     <= 6'd0;
            r_min     <= 6'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_sec     <= w_nxt_sec;
            r_min     <= w_nxt_min;
            r_running <= (w_nxt_state == ST_RUN);
            r_done    <= w_nxt_done;
            r_expired <= w_nxt_expired;
        end
    end

`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_sec <= 6'd0;
            r_pre_min <= 6'd0;
        end else if (load) begin
            r_pre_sec <= w_clamp_sec;
            r_pre_min <= w_clamp_min;
        end
    end
`endif

    assign sec     = r_sec;
    assign min     = r_min;
    assign running = r_running;
    assign done    = r_done;
    assign expired = r_expired;

endmodule

// File: tb/tb_time_countdown.sv
// Directed scoreboard bench for time_countdown: expectations queued at drive time, popped after each edge.
// Honours TIME_COUNTDOWN_AUTORELOAD_EN when the design is built with it.
module tb_time_countdown;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       load;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       stop;
    logic [5:0] sec;
    logic [5:0] min;
    logic       running;
    logic       done;
    logic       expired;

    typedef struct {
        string      tag;
        logic [5:0] min;
        logic [5:0] sec;
        logic       running;
        logic       done;
        logic       expired;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_miss;

    time_countdown #(.MAX_MIN(59)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .stop     (stop),
        .sec      (sec),
        .min      (min),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its summary line");
        $fatal(1, "timeout");
    end

    task automatic push(input string tag, input logic [5:0] e_min, input logic [5:0] e_sec,
                        input logic e_run, input logic e_done, input logic e_exp);
        exp_t e;
        e.tag = tag; e.min = e_min; e.sec = e_sec;
        e.running = e_run; e.done = e_done; e.expired = e_exp;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t        e;
        logic [14:0] obs;
        logic [14:0] exp_v;
        e     = sb.pop_front();
        obs   = {min, sec, running, done, expired};
        exp_v = {e.min, e.sec, e.running, e.done, e.expired};
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %0d:%0d run=%b done=%b exp=%b, expected %0d:%0d run=%b done=%b exp=%b",
                   e.tag, min, sec, running, done, expired,
                   e.min, e.sec, e.running, e.done, e.expired);
        end
    endtask

    // One clock cycle with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic step(input string tag, input logic i_load, input logic [5:0] i_lmin,
                        input logic [5:0] i_lsec, input logic i_start, input logic i_stop,
                        input logic i_tick, input logic [5:0] e_min, input logic [5:0] e_sec,
                        input logic e_run, input logic e_done, input logic e_exp);
        load = i_load; load_min = i_lmin; load_sec = i_lsec;
        start = i_start; stop = i_stop; tick = i_tick;
        push(tag, e_min, e_sec, e_run, e_done, e_exp);
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        compare_head();
    endtask

    initial begin
        int rem;
        n_vec = 0; n_miss = 0;
        tick = 0; load = 0; load_min = 0; load_sec = 0; start = 0; stop = 0;

        // Reset state
        reset = 1'b1;
        #3;
        push("reset_state", 6'd0, 6'd0, 0, 0, 0);
        compare_head();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full countdown from 01:05
        step("fc_load",  1, 6'd1, 6'd5, 0, 0, 0, 6'd1, 6'd5, 0, 0, 0);
        step("fc_start", 0, 6'd0, 6'd0, 1, 0, 0, 6'd1, 6'd5, 1, 0, 0);
        for (int i = 1; i <= 65; i++) begin
            rem = 65 - i;
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
            if (rem == 0)
                step("fc_tick", 0, 0, 0, 0, 0, 1, 6'd1, 6'd5, 1, 1, 0);
            else
`endif
            step("fc_tick", 0, 0, 0, 0, 0, 1, 6'(rem / 60), 6'(rem % 60),
                 rem != 0, rem == 0, rem == 0);
        end
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
        step("fc_reload_hold", 0, 0, 0, 0, 1, 0, 6'd1, 6'd5, 0, 0, 0);
`else
        step("fc_done_fall",  0, 0, 0, 0, 0, 0, 6'd0, 6'd0, 0, 0, 1);
        step("fc_tick_after", 0, 0, 0, 0, 0, 1, 6'd0, 6'd0, 0, 0, 1);
        step("fc_start_after",0, 0, 0, 1, 0, 1, 6'd0, 6'd0, 0, 0, 1);
        step("fc_stop_after", 0, 0, 0, 0, 1, 0, 6'd0, 6'd0, 0, 0, 1);
`endif

        // Pause and resume
        step("pr_load",      1, 6'd0, 6'd3, 0, 0, 0, 6'd0, 6'd3, 0, 0, 0);
        step("pr_start",     0, 0, 0, 1, 0, 0, 6'd0, 6'd3, 1, 0, 0);
        step("pr_tick1",     0, 0, 0, 0, 0, 1, 6'd0, 6'd2, 1, 0, 0);
        step("pr_stop_tick", 0, 0, 0, 0, 1, 1, 6'd0, 6'd2, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("pr_pause_tick", 0, 0, 0, 0, 0, 1, 6'd0, 6'd2, 0, 0, 0);
        step("pr_pause_stop", 0, 0, 0, 0, 1, 0, 6'd0, 6'd2, 0, 0, 0);
        step("pr_resume",     0, 0, 0, 1, 1, 0, 6'd0, 6'd2, 1, 0, 0);
        step("pr_tick2",      0, 0, 0, 0, 0, 1, 6'd0, 6'd1, 1, 0, 0);
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
        step("pr_tick3",      0, 0, 0, 0, 0, 1, 6'd0, 6'd3, 1, 1, 0);
        step("pr_done_fall",  0, 0, 0, 0, 0, 0, 6'd0, 6'd3, 1, 0, 0);
`else
        step("pr_tick3",      0, 0, 0, 0, 0, 1, 6'd0, 6'd0, 0, 1, 1);
        step("pr_done_fall",  0, 0, 0, 0, 0, 0, 6'd0, 6'd0, 0, 0, 1);
`endif

        // Clamping, load priority over start, IDLE ignores tick/stop
        step("cl_load",       1, 6'd63, 6'd60, 0, 0, 0, 6'd59, 6'd59, 0, 0, 0);
        step("cl_start",      0, 0, 0, 1, 0, 0, 6'd59, 6'd59, 1, 0, 0);
        step("cl_tick",       0, 0, 0, 0, 0, 1, 6'd59, 6'd58, 1, 0, 0);
        step("cl_load_start", 1, 6'd0, 6'd10, 1, 0, 0, 6'd0, 6'd10, 0, 0, 0);
        step("cl_idle_tick",  0, 0, 0, 0, 1, 1, 6'd0, 6'd10, 0, 0, 0);
        step("cl_sec_only",   1, 6'd2, 6'd61, 0, 0, 0, 6'd2, 6'd59, 0, 0, 0);
        step("cl_min_edge",   1, 6'd60, 6'd0, 0, 0, 0, 6'd59, 6'd0, 0, 0, 0);
        step("cl_borrow_st",  0, 0, 0, 1, 0, 0, 6'd59, 6'd0, 1, 0, 0);
        step("cl_borrow",     0, 0, 0, 0, 0, 1, 6'd58, 6'd59, 1, 0, 0);

        // Zero start: expiry without ever running; load clears expired
        step("zs_load",      1, 6'd0, 6'd0, 0, 0, 0, 6'd0, 6'd0, 0, 0, 0);
        step("zs_start",     0, 0, 0, 1, 0, 0, 6'd0, 6'd0, 0, 1, 1);
        step("zs_done_fall", 0, 0, 0, 0, 0, 1, 6'd0, 6'd0, 0, 0, 1);
        step("zs_reload",    1, 6'd0, 6'd1, 0, 0, 0, 6'd0, 6'd1, 0, 0, 0);

        // Async reset mid-run
        step("ar_load",  1, 6'd2, 6'd30, 0, 0, 0, 6'd2, 6'd30, 0, 0, 0);
        step("ar_start", 0, 0, 0, 1, 0, 0, 6'd2, 6'd30, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            rem = 150 - i;
            step("ar_tick", 0, 0, 0, 0, 0, 1, 6'(rem / 60), 6'(rem % 60), 1, 0, 0);
        end
        #2;
        reset = 1'b1;
        #1;
        push("ar_async_clear", 6'd0, 6'd0, 0, 0, 0);
        compare_head();
        @(negedge clk);
        reset = 1'b0;
        step("ar_after_reset", 0, 0, 0, 0, 0, 1, 6'd0, 6'd0, 0, 0, 0);
        step("ar_zero_start",  0, 0, 0, 1, 0, 0, 6'd0, 6'd0, 0, 1, 1);

`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
        // Auto-reload from 00:02
        step("au_load",  1, 6'd0, 6'd2, 0, 0, 0, 6'd0, 6'd2, 0, 0, 0);
        step("au_start", 0, 0, 0, 1, 0, 0, 6'd0, 6'd2, 1, 0, 0);
        step("au_tick1", 0, 0, 0, 0, 0, 1, 6'd0, 6'd1, 1, 0, 0);
        step("au_tick2", 0, 0, 0, 0, 0, 1, 6'd0, 6'd2, 1, 1, 0);
        step("au_tick3", 0, 0, 0, 0, 0, 1, 6'd0, 6'd1, 1, 0, 0);
        step("au_tick4", 0, 0, 0, 0, 0, 1, 6'd0, 6'd2, 1, 1, 0);
        step("au_idle",  0, 0, 0, 0, 0, 0, 6'd0, 6'd2, 1, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/time_countdown.md
# time_countdown

Loadable minutes:seconds countdown timer that is the decrementing counterpart of the up-counting time counter. It shares the same 6-bit `sec`/`min` output format, so the display and readout logic used with the up-counter can read either block. The timer decrements on an external `tick` enable, exposes run/pause control, and signals expiry with a one-cycle `done` pulse plus a sticky `expired` flag.

## Interface
- `MAX_MIN`, default 59: largest loadable minute value; larger loads clamp to it. Legal range 0..63.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `tick`  in  1: decrement enable, typically a 1 Hz strobe one `clk` cycle wide. It is sampled every cycle.
- `load`  in  1: load preset.
- `load_min`  in  6: preset minutes.
- `load_sec`  in  6: preset seconds.
- `start`  in  1: begin or resume counting.
- `stop`  in  1: pause counting.
- `sec`  out  6: remaining seconds, 0..59.
- `min`  out  6: remaining minutes, 0..MAX_MIN.
- `running`  out  1: high while in RUN.
- `done`  out  1: one-cycle expiry pulse.
- `expired`  out  1: sticky expiry flag.

## Operation
- **Reset (async):** `sec`=0, `min`=0, internal saved preset=00:00, `running`=0, `done`=0, `expired`=0, state=IDLE.
- **States:** IDLE, RUN, PAUSE, DONE. `running` = (state==RUN), registered.
- **Load:** `load` has priority over every other input in every state.
  - `sec` <= min(`load_sec`, 59). `min` <= min(`load_min`, MAX_MIN).
  - The saved preset takes the same clamped values.
  - state <= IDLE, `expired` <= 0, `done` <= 0.
  - A `start` in the same cycle as `load` is ignored.
- **IDLE:**
  - `start` with a nonzero value: go to RUN.
  - `start` with 00:00: go to DONE; `done` pulses and `expired` is set.
  - `tick` and `stop` are ignored.
- **RUN:**
  - `stop` goes to PAUSE. If `tick` arrives in the same cycle, no decrement happens.
  - Otherwise `tick` decrements the value:
    - if `sec`>0: `sec`-1;
    - else if `min`>0: `sec`<=59 and `min`-1.
  - A decrement that produces 00:00 goes to DONE, pulses `done` and sets `expired`.
- **PAUSE:**
  - Value is held and `tick` is ignored.
  - `start` returns to RUN.
  - `stop` has no effect.
- **DONE:**
  - Holds 00:00.
  - `start`, `stop` and `tick` are ignored. Only `load` or `reset` leave this state.
- **Simultaneous `start` and `stop`:** `stop` wins in RUN, `start` wins in PAUSE/IDLE.
- **Arithmetic:** 6-bit, no wrap below 00:00. `sec` never exceeds 59.

## Timing
- All outputs are registered.
- **Decrement:** a `tick` sampled at edge N updates `sec`/`min` at edge N.
- **Expiry:** `done` rises at the same edge that `sec`/`min` become 00:00 and falls at the next edge. `expired` stays high until `load` or `reset`.
- **Control:** `start`/`stop` take effect at the sampling edge, and `running` changes at that edge. The first decrement after `start` needs a `tick` in a later cycle.
- **Reset mid-operation:** outputs clear immediately, independent of `clk`.

## Configuration
- Macro: `TIME_COUNTDOWN_AUTORELOAD_EN`.
- **Defined:** on the decrement to 00:00 in RUN:
  - `sec`/`min` reload from the saved preset and the state stays RUN;
  - `done` pulses for one cycle;
  - `expired` is not set.
  - If the saved preset is 00:00, the block behaves as in the undefined case.
- **Undefined:** the block behaves as in Operation; the saved preset register may be optimized away.

## Test plan
- **Full countdown:** load 01:05, start, then 65 ticks.
  - After tick 5: 01:00. After tick 6: 00:59.
  - After tick 65: 00:00, `done` high for exactly 1 cycle, `expired`=1, `running`=0.
  - Further ticks and `start` leave 00:00.
- **Pause and resume:** load 00:03, start, 1 tick (00:02), then `stop` and `tick` in the same cycle.
  - Value stays 00:02 and `running`=0; 5 more ticks change nothing.
  - `start` then 2 ticks: 00:00 and `done` pulses.
- **Clamping:** `load_min`=63, `load_sec`=60 with MAX_MIN=59 gives 59:59. Then `load` and `start` together gives the new value, state IDLE, `running`=0.
- **Zero start:** load 00:00, start gives `done` pulse next edge, `expired`=1, `running` never asserted.
- **Async reset:** load 02:30, start, 10 ticks, then assert `reset` between clock edges. `sec`=`min`=0 and all flags are 0 immediately.
- **Auto-reload (macro defined):** load 00:02, start, 4 ticks.
  - `done` pulses after tick 2 and tick 4.
  - Value reads 00:02 after each pulse, `running` stays 1, `expired` stays 0.
